soc_bus_ctrl: RTL and testbench
===============================

// Module: soc_bus_ctrl
// PURPOSE
//  Parametrised bus fabric between the 65Org16-style cpu and NSLV peripherals.
//  Decodes AB[AW-1:AW-8] against per-slave tag/mask and generates one-hot selects.
//  Inserts per-slave wait states through cpu RDY and registers read data onto DI.
//  Replaces the hard-wired decode and read mux of the single-board tops.
// PARAMETERS
//  DW       16          data width (bytesize); 8 also supported
//  AW       2*DW        address width
//  NSLV     4           number of slaves, 1..8
//  SLV_TAG  NSLV*8 bits slave i tag at [8i+7:8i], compared with AB[AW-1:AW-8]
//  SLV_MASK NSLV*8 bits slave i mask at [8i+7:8i]; 1 = bit compared
//  SLV_WAIT NSLV*4 bits slave i fixed wait states W at [4i+3:4i], 0..15
//  DEF_DATA {DW{1'b0}}  read data returned for unmapped or aborted accesses
//  TIMEOUT  64          hold-cycle limit, 1..255; used only with BUS_TIMEOUT_EN
// PORTS
//  clk        in   1       single clock, all flops on posedge
//  reset      in   1       synchronous, active-high
//  AB         in   AW      cpu address
//  DO         in   DW      cpu write data
//  WE         in   1       cpu write enable
//  RDY        out  1       to cpu RDY; low stalls cpu (cpu holds AB/DO/WE)
//  DI         out  DW      registered read data to cpu
//  slv_sel    out  NSLV    one-hot select, held for whole access
//  slv_we     out  1       one-cycle write strobe on completing cycle
//  slv_re     out  1       one-cycle read strobe on completing cycle
//  slv_wdata  out  DW      = DO (pass-through)
//  slv_addr   out  AW-8    = AB[AW-9:0]
//  slv_rdata  in   NSLV*DW slave i read data at [DW*i+DW-1:DW*i]; valid on completing cycle
//  slv_hold   in   NSLV    slave i extends access while high once its counter reaches 0
//  bus_err    out  1       one-cycle pulse: unmapped access or timeout abort
// BEHAVIOUR
//  Decode: slave i matches when ((AB[AW-1:AW-8]^TAG_i)&MASK_i)==0.
//   Lowest index wins. No match: unmapped.
//  States: IDLE, WAIT.
//   IDLE: every cycle is an access start. Latch slave index idx and WE.
//    W==0 and slv_hold[idx]==0: complete this cycle, RDY=1.
//    W>0: RDY=0, cnt<=W-1, go WAIT.
//    W==0 and hold high: RDY=0, go WAIT with cnt=0.
//   WAIT: uses latched idx/WE only; AB changes are ignored.
//    cnt!=0: RDY=0, cnt--.
//    cnt==0 and hold[idx] high: RDY=0, stay.
//    cnt==0 and hold low: complete, RDY=1, go IDLE.
//  RDY is combinational from state, cnt, decode and hold (documented cpu RDY path).
//  Completing cycle:
//   slv_we=WE, slv_re=!WE for exactly that cycle.
//   Read: DI<=slv_rdata[idx] at that posedge, so new DI is visible the cycle after RDY=1.
//   DI holds its value otherwise, including across writes.
//  Access length = W+1+hold cycles. RDY low for W+hold cycles.
//  Back-to-back zero-wait accesses sustain one access per cycle.
//  Unmapped: completes with zero waits; slv_sel=0; no strobes; DI<=DEF_DATA on read;
//   write dropped; bus_err pulses in the completing cycle.
//  Reset (any state, mid-access included), applied at the next posedge:
//   IDLE, cnt=0, DI=0, slv_sel=0, slv_we=slv_re=0, bus_err=0, RDY=1.
//   The access in flight is abandoned without a strobe.
//  cnt is 4 bits and never wraps (decrement only when !=0).
// CONFIGURATION
//  BUS_TIMEOUT_EN defined:
//   An 8-bit hold counter runs while in WAIT with cnt==0 and hold high.
//   On reaching TIMEOUT, the access completes: RDY=1, no strobe, DI<=DEF_DATA on read,
//    bus_err pulses.
//   The hold counter clears at every access start.
//  BUS_TIMEOUT_EN undefined: no hold counter; slv_hold may stall the cpu indefinitely;
//   bus_err flags unmapped accesses only.
// TESTING
//  1 Zero-wait read of slave 0, slv_rdata0=16'h1234: RDY stays 1, slv_re 1 cycle, DI=16'h1234 next cycle.
//  2 SLV_WAIT1=3, write 16'hBEEF to slave 1: RDY low 3 cycles, slv_sel held, slv_we exactly 1 pulse on cycle 4.
//  3 Read AB=32'h8000_0010 matching no tag: DI=DEF_DATA, bus_err 1 pulse, slv_sel=0, no strobes.
//  4 slv_hold2 high 5 cycles after W=1 on slave 2: RDY low 6 cycles, data captured when hold drops.
//  5 Reset asserted in WAIT with cnt=2: next cycle RDY=1, DI=0, slv_sel=0, no strobe ever issued.
//  6 BUS_TIMEOUT_EN, TIMEOUT=8, hold stuck high: abort after 8 hold cycles, bus_err pulse, DI=DEF_DATA.

Source files
------------

// File: rtl/soc_bus_ctrl.sv
// Bus fabric between a 65Org16-style cpu and NSLV slaves: tag/mask decode, wait states, read mux.
// Optional hold timeout abort is compiled in with `define BUS_TIMEOUT_EN.
module soc_bus_ctrl #(
  parameter int                 DW       = 16,
  parameter int                 AW       = 2*DW,
  parameter int                 NSLV     = 4,
  parameter logic [NSLV*8-1:0]  SLV_TAG  = 32'h2020_1000,
  parameter logic [NSLV*8-1:0]  SLV_MASK = 32'hE0F0_F0F0,
  parameter logic [NSLV*4-1:0]  SLV_WAIT = 16'h2130,
  parameter logic [DW-1:0]      DEF_DATA = {DW{1'b0}},
  parameter int                 TIMEOUT  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AW-1:0]        AB,
  input  logic [DW-1:0]        DO,
  input  logic                 WE,
  output logic                 RDY,
  output logic [DW-1:0]        DI,
  output logic [NSLV-1:0]      slv_sel,
  output logic                 slv_we,
  output logic                 slv_re,
  output logic [DW-1:0]        slv_wdata,
  output logic [AW-9:0]        slv_addr,
  input  logic [NSLV*DW-1:0]   slv_rdata,
  input  logic [NSLV-1:0]      slv_hold,
  output logic                 bus_err
);

  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

  if (NSLV < 1 || NSLV > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
    $error("soc_bus_ctrl: NSLV must be 1..8 and TIMEOUT 1..255");
  end

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state_reg;
  logic [3:0]      cnt_reg;
  logic [IW-1:0]   idx_reg;
  logic            we_reg;
  logic [DW-1:0]   di_reg;

  logic [NSLV-1:0] match;
  logic [3:0]      wait_tbl  [NSLV];
  logic [DW-1:0]   rdata_tbl [NSLV];

  genvar gi;
  generate
    for (gi = 0; gi < NSLV; gi++) begin : g_slv
      assign match[gi]     = ((AB[AW-1:AW-8] ^ SLV_TAG[8*gi +: 8]) & SLV_MASK[8*gi +: 8]) == 8'd0;
      assign wait_tbl[gi]  = SLV_WAIT[4*gi +: 4];
      assign rdata_tbl[gi] = slv_rdata[DW*gi +: DW];
    end
  endgenerate

  // Priority decode: scanning downwards lets the lowest matching index win.
  logic          hit;
  logic [IW-1:0] dec_idx;
  always_comb begin
    hit     = 1'b0;
    dec_idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        dec_idx = IW'(i);
      end
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIMIT = 8'(TIMEOUT);
  logic [7:0] hcnt_reg;
`endif

  // In IDLE the live decode drives the access; in WAIT only the latched target counts.
  logic [IW-1:0] cur_idx;
  logic          cur_we;
  logic          cur_hit;
  logic          complete;
  logic          abort;
  always_comb begin
    cur_idx  = (state_reg == IDLE) ? dec_idx : idx_reg;
    cur_we   = (state_reg == IDLE) ? WE : we_reg;
    cur_hit  = (state_reg == IDLE) ? hit : 1'b1;
    abort    = 1'b0;
    complete = 1'b0;
    if (state_reg == IDLE) begin
      complete = !hit || (wait_tbl[dec_idx] == 4'd0 && !slv_hold[dec_idx]);
    end else if (cnt_reg == 4'd0) begin
`ifdef BUS_TIMEOUT_EN
      abort = (hcnt_reg == HOLD_LIMIT);
`endif
      complete = abort || !slv_hold[idx_reg];
    end
  end

  // Reset masks the combinational outputs so an abandoned access never strobes.
  assign RDY       = reset | complete;
  assign slv_we    = !reset && complete && cur_hit && !abort && cur_we;
  assign slv_re    = !reset && complete && cur_hit && !abort && !cur_we;
  assign bus_err   = !reset && complete && (!cur_hit || abort);
  assign slv_wdata = DO;
  assign slv_addr  = AB[AW-9:0];
  assign DI        = di_reg;

  always_comb begin
    slv_sel = '0;
    if (!reset && cur_hit) slv_sel[cur_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      idx_reg   <= '0;
      we_reg    <= 1'b0;
      di_reg    <= '0;
`ifdef BUS_TIMEOUT_EN
      hcnt_reg  <= 8'd0;
`endif
    end else begin
      if (complete && !cur_we)
        di_reg <= (cur_hit && !abort) ? rdata_tbl[cur_idx] : DEF_DATA;
      case (state_reg)
        IDLE: begin
          idx_reg <= dec_idx;
          we_reg  <= WE;
`ifdef BUS_TIMEOUT_EN
          hcnt_reg <= 8'd0;
`endif
          if (!complete) begin
            state_reg <= WAIT;
            cnt_reg   <= (wait_tbl[dec_idx] == 4'd0) ? 4'd0 : wait_tbl[dec_idx] - 4'd1;
          end
        end
        WAIT: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else if (complete) begin
            state_reg <= IDLE;
          end else begin
`ifdef BUS_TIMEOUT_EN
            hcnt_reg <= hcnt_reg + 8'd1;
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_bus_ctrl.sv
// Self-checking bench for soc_bus_ctrl: directed scenarios plus randomized accesses
// checked against a per-access behavioural model (decode table, wait length, hold schedule).
module tb_soc_bus_ctrl;

  localparam int DW = 16;
  localparam int AW = 32;
  localparam int NSLV = 4;
  localparam logic [NSLV*8-1:0] P_TAG  = 32'h2020_1000;
  localparam logic [NSLV*8-1:0] P_MASK = 32'hE0F0_F0F0;
  localparam logic [NSLV*4-1:0] P_WAIT = 16'h2130;
  localparam logic [DW-1:0]     P_DEF  = 16'hDEAD;
  localparam int                P_TIMEOUT = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [AW-1:0]      AB = '0;
  logic [DW-1:0]      DO = '0;
  logic               WE = 1'b0;
  logic               RDY;
  logic [DW-1:0]      DI;
  logic [NSLV-1:0]    slv_sel;
  logic               slv_we;
  logic               slv_re;
  logic [DW-1:0]      slv_wdata;
  logic [AW-9:0]      slv_addr;
  logic [NSLV*DW-1:0] slv_rdata = '0;
  logic [NSLV-1:0]    slv_hold = '0;
  logic               bus_err;

  soc_bus_ctrl #(
    .DW(DW), .AW(AW), .NSLV(NSLV), .SLV_TAG(P_TAG), .SLV_MASK(P_MASK),
    .SLV_WAIT(P_WAIT), .DEF_DATA(P_DEF), .TIMEOUT(P_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .AB(AB), .DO(DO), .WE(WE), .RDY(RDY), .DI(DI),
    .slv_sel(slv_sel), .slv_we(slv_we), .slv_re(slv_re), .slv_wdata(slv_wdata),
    .slv_addr(slv_addr), .slv_rdata(slv_rdata), .slv_hold(slv_hold), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] di_model = '0;

  // Slave map as a plain table: slave 3 overlaps slave 2 on 0x2X, so priority matters.
  logic [7:0] tag_m  [NSLV] = '{8'h00, 8'h10, 8'h20, 8'h20};
  logic [7:0] mask_m [NSLV] = '{8'hF0, 8'hF0, 8'hF0, 8'hE0};
  int         wait_m [NSLV] = '{0, 3, 1, 2};

  function automatic int model_decode(input logic [7:0] top);
    for (int i = 0; i < NSLV; i++)
      if (((top ^ tag_m[i]) & mask_m[i]) == 8'h00) return i;
    return -1;
  endfunction

  // One access: the model predicts RDY low for W+H cycles, completing on cycle W+H.
  // The target's hold is high exactly on cycles W..W+H-1; other slaves' holds are noise.
  task automatic run_access(input logic [AW-1:0] ab, input logic we, input logic [DW-1:0] dout,
                            input int h_in, input int fixed_rd, input string name);
    int s, w, h, len;
    logic [DW-1:0]   rd [NSLV];
    logic [NSLV-1:0] sel_exp;
    logic            fin;
    s = model_decode(ab[AW-1:AW-8]);
    w = (s < 0) ? 0 : wait_m[s];
    h = (s < 0) ? 0 : h_in;
    len = w + h;
    for (int i = 0; i < NSLV; i++) rd[i] = DW'($urandom);
    if (s >= 0 && fixed_rd >= 0) rd[s] = DW'(fixed_rd);
    sel_exp = (s < 0) ? '0 : (NSLV'(1) << s);
    for (int k = 0; k <= len; k++) begin
      @(negedge clk);
      reset = 1'b0;
      AB = (k == 0) ? ab : {8'($urandom), ab[AW-9:0]};
      DO = dout;
      WE = we;
      for (int i = 0; i < NSLV; i++) slv_rdata[DW*i +: DW] = rd[i];
      slv_hold = NSLV'($urandom);
      if (s >= 0 && k >= w) slv_hold[s] = (k < len);
      #1;
      fin = (k == len);
      checks++;
      if (RDY !== fin) begin
        errors++; $display("FAIL %s rdy k=%0d got %b exp %b", name, k, RDY, fin);
      end
      checks++;
      if (slv_sel !== sel_exp) begin
        errors++; $display("FAIL %s slv_sel k=%0d got %b exp %b", name, k, slv_sel, sel_exp);
      end
      checks++;
      if (slv_we !== (fin && s >= 0 && we)) begin
        errors++; $display("FAIL %s slv_we k=%0d got %b exp %b", name, k, slv_we, fin && s >= 0 && we);
      end
      checks++;
      if (slv_re !== (fin && s >= 0 && !we)) begin
        errors++; $display("FAIL %s slv_re k=%0d got %b exp %b", name, k, slv_re, fin && s >= 0 && !we);
      end
      checks++;
      if (bus_err !== (fin && s < 0)) begin
        errors++; $display("FAIL %s bus_err k=%0d got %b exp %b", name, k, bus_err, fin && s < 0);
      end
      checks++;
      if (slv_wdata !== dout) begin
        errors++; $display("FAIL %s slv_wdata k=%0d got %h exp %h", name, k, slv_wdata, dout);
      end
      if (k == 0) begin
        checks++;
        if (slv_addr !== ab[AW-9:0]) begin
          errors++; $display("FAIL %s slv_addr got %h exp %h", name, slv_addr, ab[AW-9:0]);
        end
      end
    end
    if (!we) di_model = (s < 0) ? P_DEF : rd[s];
    @(posedge clk);
    #1;
    checks++;
    if (DI !== di_model) begin
      errors++; $display("FAIL %s di got %h exp %h", name, DI, di_model);
    end
    $display("%s ab=%h we=%b slave=%0d hold=%0d cycles=%0d di=%h", name, ab, we, s, h, len + 1, DI);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    AB = 32'h1000_0000;
    WE = 1'b0;
    @(posedge clk); @(posedge clk);
    #1;
    checks++;
    if (RDY !== 1'b1) begin errors++; $display("FAIL reset rdy got %b exp 1", RDY); end
    checks++;
    if (DI !== '0) begin errors++; $display("FAIL reset di got %h exp 0", DI); end
    checks++;
    if (slv_sel !== '0) begin errors++; $display("FAIL reset slv_sel got %b exp 0", slv_sel); end
    checks++;
    if ({slv_we, slv_re, bus_err} !== 3'b000) begin
      errors++; $display("FAIL reset strobes got %b exp 000", {slv_we, slv_re, bus_err});
    end
    di_model = '0;
    $display("reset di=%h rdy=%b", DI, RDY);
  endtask

  task automatic test_zero_wait_read();
    run_access(32'h0000_0010, 1'b0, 16'h0000, 0, 16'h1234, "zero_wait_read");
  endtask

  task automatic test_wait_write();
    run_access(32'h1000_0020, 1'b1, 16'hBEEF, 0, -1, "wait3_write");
  endtask

  task automatic test_unmapped();
    run_access(32'h8000_0010, 1'b0, 16'h0000, 0, -1, "unmapped_read");
    run_access(32'h4000_0004, 1'b1, 16'h5555, 0, -1, "unmapped_write");
  endtask

  task automatic test_hold();
    run_access(32'h2000_0030, 1'b0, 16'h0000, 5, 16'hC0DE, "hold5_read");
    run_access(32'h0000_0008, 1'b0, 16'h0000, 3, -1, "hold3_w0_read");
    run_access(32'h3000_0000, 1'b0, 16'h0000, 2, -1, "prio_slave3_read");
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = cyc;
    for (int i = 0; i < 8; i++)
      run_access({8'h05, 24'($urandom)}, 1'($urandom), 16'($urandom), 0, -1, "b2b");
    checks++;
    if (cyc - c0 !== 8) begin
      errors++; $display("FAIL back_to_back cycles got %0d exp 8", cyc - c0);
    end
  endtask

  task automatic test_random();
    logic [7:0] top;
    for (int n = 0; n < 40; n++) begin
      top = 8'($urandom_range(0, 8'h5F));
      run_access({top, 24'($urandom)}, 1'($urandom), 16'($urandom), $urandom_range(0, 5), -1, "rand");
    end
  endtask

  task automatic test_reset_mid_access();
    run_access(32'h0000_0000, 1'b0, 16'h0000, 0, 16'hA5A5, "pre_reset_read");
    @(negedge clk);
    AB = 32'h1000_0000;
    WE = 1'b0;
    slv_hold = '0;
    #1;
    checks++;
    if (RDY !== 1'b0) begin errors++; $display("FAIL mid_reset start rdy got %b exp 0", RDY); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({slv_we, slv_re} !== 2'b00) begin
      errors++; $display("FAIL mid_reset strobe got %b exp 00", {slv_we, slv_re});
    end
    @(posedge clk);
    #1;
    checks++;
    if (RDY !== 1'b1) begin errors++; $display("FAIL mid_reset rdy got %b exp 1", RDY); end
    checks++;
    if (DI !== '0) begin errors++; $display("FAIL mid_reset di got %h exp 0", DI); end
    checks++;
    if (slv_sel !== '0) begin errors++; $display("FAIL mid_reset slv_sel got %b exp 0", slv_sel); end
    checks++;
    if ({slv_we, slv_re, bus_err} !== 3'b000) begin
      errors++; $display("FAIL mid_reset strobes got %b exp 000", {slv_we, slv_re, bus_err});
    end
    di_model = '0;
    $display("reset_mid_access di=%h rdy=%b sel=%b", DI, RDY, slv_sel);
    run_access(32'h1000_0000, 1'b0, 16'h0000, 0, -1, "post_reset_read");
  endtask

`ifdef BUS_TIMEOUT_EN
  task automatic test_timeout();
    // Slave 2 has one wait state, then TIMEOUT hold cycles before the abort cycle.
    for (int k = 0; k <= 1 + P_TIMEOUT; k++) begin
      @(negedge clk);
      AB = 32'h2000_0000;
      WE = 1'b0;
      slv_hold = NSLV'($urandom) | 4'b0100;
      #1;
      checks++;
      if (RDY !== (k == 1 + P_TIMEOUT)) begin
        errors++; $display("FAIL timeout rdy k=%0d got %b exp %b", k, RDY, k == 1 + P_TIMEOUT);
      end
      checks++;
      if (bus_err !== (k == 1 + P_TIMEOUT)) begin
        errors++; $display("FAIL timeout bus_err k=%0d got %b exp %b", k, bus_err, k == 1 + P_TIMEOUT);
      end
      checks++;
      if ({slv_we, slv_re} !== 2'b00) begin
        errors++; $display("FAIL timeout strobe k=%0d got %b exp 00", k, {slv_we, slv_re});
      end
    end
    di_model = P_DEF;
    @(posedge clk);
    #1;
    checks++;
    if (DI !== P_DEF) begin errors++; $display("FAIL timeout di got %h exp %h", DI, P_DEF); end
    $display("timeout abort di=%h", DI);
  endtask
`endif

  initial begin
    test_reset();
    test_zero_wait_read();
    test_wait_write();
    test_unmapped();
    test_hold();
    test_back_to_back();
    test_random();
`ifdef BUS_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
